// File: rtl/sonic_tx_stats_pkg.sv
// Shared constants for the 10G TX status statistics block: status/error bit
// positions, CSR word addresses and event counter slots.
package sonic_tx_stats_pkg;

    localparam int ST_LEN_W     = 16;
    localparam int ST_UNICAST   = 16;
    localparam int ST_MULTICAST = 17;
    localparam int ST_BROADCAST = 18;
    localparam int ST_PAUSE     = 19;

    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_CRC       = 1;
    localparam int ERR_OVERSIZE  = 2;
    localparam int ERR_UNDERSIZE = 3;

    localparam logic [3:0] ADDR_FRAMES_OK  = 4'd0;
    localparam logic [3:0] ADDR_FRAMES_ERR = 4'd1;
    localparam logic [3:0] ADDR_OCTETS_LO  = 4'd2;
    localparam logic [3:0] ADDR_OCTETS_HI  = 4'd3;
    localparam logic [3:0] ADDR_UNICAST    = 4'd4;
    localparam logic [3:0] ADDR_MULTICAST  = 4'd5;
    localparam logic [3:0] ADDR_BROADCAST  = 4'd6;
    localparam logic [3:0] ADDR_PAUSE      = 4'd7;
    localparam logic [3:0] ADDR_UNDERFLOW  = 4'd8;
    localparam logic [3:0] ADDR_CRC        = 4'd9;
    localparam logic [3:0] ADDR_OVERSIZE   = 4'd10;
    localparam logic [3:0] ADDR_UNDERSIZE  = 4'd11;
    localparam logic [3:0] ADDR_CONTROL    = 4'd15;

    localparam int CTRL_CLEAR_BIT = 0;

    // Event counter slots (the octet counter is separate and wider)
    localparam int EV_OK        = 0;
    localparam int EV_ERR       = 1;
    localparam int EV_UNICAST   = 2;
    localparam int EV_MULTICAST = 3;
    localparam int EV_BROADCAST = 4;
    localparam int EV_PAUSE     = 5;
    localparam int EV_UNDERFLOW = 6;
    localparam int EV_CRC       = 7;
    localparam int EV_OVERSIZE  = 8;
    localparam int EV_UNDERSIZE = 9;
    localparam int NUM_EV       = 10;

endpackage

// File: rtl/sonic_tx_stat_counter.sv
// Single statistics counter: adds inc every cycle, optional saturation,
// and a clear that restarts from zero without dropping that cycle's inc.
module sonic_tx_stat_counter #(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nxt;

    always_comb begin
        base = clr ? '0 : count;
        sum  = {1'b0, base} + {1'b0, inc};
        nxt  = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else          count <= nxt;
    end

endmodule

// File: rtl/sonic_eth_10g_tx_status_stats.sv
// TX status statistics: S1 registers the status beat, S2 classifies it and
// feeds the counter bank; counters are read over a small Avalon-MM port.
module sonic_eth_10g_tx_status_stats
    import sonic_tx_stats_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [39:0] in_data,
    input  logic [6:0]  in_error,
    output logic        in_ready,
    input  logic [3:0]  csr_address,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata
);

    localparam int OCT_W = 2 * CNT_W;

    logic                            s1_valid;
    logic [19:0]                     s1_data;
    logic [6:0]                      s1_error;
    logic [ST_LEN_W-1:0]             s1_len;
    logic                            frame_ok;
    logic                            frame_err;
    logic [NUM_EV-1:0]               ev_hit;
    logic [NUM_EV-1:0][CNT_W-1:0]    ev_cnt;
    logic [OCT_W-1:0]                oct_inc;
    logic [OCT_W-1:0]                oct_cnt;
    logic [CNT_W-1:0]                oct_snap;
    logic                            clear_pending;
    logic [31:0]                     rd_mux;
    logic                            unused_bits;

    assign unused_bits = ^{in_data[39:20], csr_writedata[31:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_error <= '0;
            in_ready <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            s1_data  <= in_data[19:0];
            s1_error <= in_error;
            in_ready <= 1'b1;
        end
    end

    assign s1_len    = s1_data[ST_LEN_W-1:0];
    assign frame_ok  = s1_valid && (s1_error == '0);
    assign frame_err = s1_valid && (s1_error != '0);

    always_comb begin
        ev_hit               = '0;
        ev_hit[EV_OK]        = frame_ok;
        ev_hit[EV_ERR]       = frame_err;
        ev_hit[EV_UNICAST]   = frame_ok  && s1_data[ST_UNICAST];
        ev_hit[EV_MULTICAST] = frame_ok  && s1_data[ST_MULTICAST];
        ev_hit[EV_BROADCAST] = frame_ok  && s1_data[ST_BROADCAST];
        ev_hit[EV_PAUSE]     = frame_ok  && s1_data[ST_PAUSE];
        ev_hit[EV_UNDERFLOW] = frame_err && s1_error[ERR_UNDERFLOW];
        ev_hit[EV_CRC]       = frame_err && s1_error[ERR_CRC];
        ev_hit[EV_OVERSIZE]  = frame_err && s1_error[ERR_OVERSIZE];
        ev_hit[EV_UNDERSIZE] = frame_err && s1_error[ERR_UNDERSIZE];
    end

    for (genvar i = 0; i < NUM_EV; i++) begin : g_ev
        sonic_tx_stat_counter #(.WIDTH(CNT_W), .SATURATE(SATURATE != 0)) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (CNT_W'(ev_hit[i])),
            .clr     (clear_pending),
            .count   (ev_cnt[i])
        );
    end

    if (OCT_W >= ST_LEN_W) begin : g_oct_wide
        assign oct_inc = frame_ok ? OCT_W'(s1_len) : '0;
    end else begin : g_oct_narrow
        // A length beyond the counter range saturates outright, or wraps
        // modulo 2^OCT_W when saturation is off.
        logic len_ovf;
        assign len_ovf = |(s1_len >> OCT_W);
        assign oct_inc = !frame_ok                    ? '0 :
                         ((SATURATE != 0) && len_ovf) ? '1 : s1_len[OCT_W-1:0];
    end

    sonic_tx_stat_counter #(.WIDTH(OCT_W), .SATURATE(SATURATE != 0)) u_oct (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (oct_inc),
        .clr     (clear_pending),
        .count   (oct_cnt)
    );

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            ADDR_FRAMES_OK:  rd_mux = 32'(ev_cnt[EV_OK]);
            ADDR_FRAMES_ERR: rd_mux = 32'(ev_cnt[EV_ERR]);
            ADDR_OCTETS_LO:  rd_mux = 32'(oct_cnt[CNT_W-1:0]);
            ADDR_OCTETS_HI:  rd_mux = 32'(oct_snap);
            ADDR_UNICAST:    rd_mux = 32'(ev_cnt[EV_UNICAST]);
            ADDR_MULTICAST:  rd_mux = 32'(ev_cnt[EV_MULTICAST]);
            ADDR_BROADCAST:  rd_mux = 32'(ev_cnt[EV_BROADCAST]);
            ADDR_PAUSE:      rd_mux = 32'(ev_cnt[EV_PAUSE]);
            ADDR_UNDERFLOW:  rd_mux = 32'(ev_cnt[EV_UNDERFLOW]);
            ADDR_CRC:        rd_mux = 32'(ev_cnt[EV_CRC]);
            ADDR_OVERSIZE:   rd_mux = 32'(ev_cnt[EV_OVERSIZE]);
            ADDR_UNDERSIZE:  rd_mux = 32'(ev_cnt[EV_UNDERSIZE]);
            ADDR_CONTROL:    rd_mux = {31'b0, clear_pending};
            default:         rd_mux = '0;
        endcase
    end

    // Reading the low octet word freezes the high half so the pair is coherent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clear_pending <= 1'b0;
            oct_snap      <= '0;
            csr_readdata  <= '0;
        end else begin
            clear_pending <= csr_write && (csr_address == ADDR_CONTROL) &&
                             csr_writedata[CTRL_CLEAR_BIT];
            if (clear_pending)
                oct_snap <= '0;
            else if (csr_read && (csr_address == ADDR_OCTETS_LO))
                oct_snap <= oct_cnt[OCT_W-1:CNT_W];
            if (csr_read)
                csr_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sonic_eth_10g_tx_status_stats.sv
// Self-checking bench: four configurations share one stimulus stream and are
// checked against a transaction-level counter model.
module tb_sonic_eth_10g_tx_status_stats;

    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [39:0] in_data = '0;
    logic [6:0]  in_error = '0;
    logic [3:0]  csr_address = '0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic        rdy [NC];
    logic [31:0] rdd [NC];

    int cw [NC] = '{32, 8, 4, 4};
    bit cs [NC] = '{1'b1, 1'b1, 1'b1, 1'b0};

    logic [63:0] m_ev [NC][10];
    logic [63:0] m_oct [NC];
    logic [63:0] m_snap [NC];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        localparam int W = (g == 0) ? 32 : (g == 1) ? 8 : 4;
        localparam int S = (g == 3) ? 0 : 1;
        sonic_eth_10g_tx_status_stats #(.CNT_W(W), .SATURATE(S)) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .in_valid      (in_valid),
            .in_data       (in_data),
            .in_error      (in_error),
            .in_ready      (rdy[g]),
            .csr_address   (csr_address),
            .csr_read      (csr_read),
            .csr_write     (csr_write),
            .csr_writedata (csr_writedata),
            .csr_readdata  (rdd[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] madd(input logic [63:0] a, input logic [63:0] b,
                                         input int w, input bit s);
        logic [64:0] sum, mx, wr;
        mx  = (65'd1 << w) - 65'd1;
        sum = {1'b0, a} + {1'b0, b};
        wr  = sum & mx;
        if (s && sum > mx) return mx[63:0];
        return s ? sum[63:0] : wr[63:0];
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < 10; k++) m_ev[c][k] = '0;
            m_oct[c]  = '0;
            m_snap[c] = '0;
        end
    endtask

    task automatic model_frame(input logic [15:0] len, input logic [3:0] ty, input logic [6:0] err);
        for (int c = 0; c < NC; c++) begin
            if (err == '0) begin
                m_ev[c][0] = madd(m_ev[c][0], 64'd1, cw[c], cs[c]);
                m_oct[c]   = madd(m_oct[c], 64'(len), 2 * cw[c], cs[c]);
                for (int k = 0; k < 4; k++)
                    m_ev[c][2+k] = madd(m_ev[c][2+k], 64'(ty[k]), cw[c], cs[c]);
            end else begin
                m_ev[c][1] = madd(m_ev[c][1], 64'd1, cw[c], cs[c]);
                for (int k = 0; k < 4; k++)
                    m_ev[c][6+k] = madd(m_ev[c][6+k], 64'(err[k]), cw[c], cs[c]);
            end
        end
    endtask

    function automatic logic [63:0] exp_rd(input int c, input logic [3:0] a);
        logic [63:0] mask;
        mask = (64'd1 << cw[c]) - 64'd1;
        if (a == 4'd0 || a == 4'd1) return m_ev[c][a];
        if (a == 4'd2) return m_oct[c] & mask;
        if (a == 4'd3) return m_snap[c];
        if (a >= 4'd4 && a <= 4'd11) return m_ev[c][int'(a) - 2];
        return '0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        cyc();
        cyc();
    endtask

    task automatic send(input logic [15:0] len, input logic [3:0] ty, input logic [6:0] err);
        in_valid = 1'b1;
        in_data  = {20'($urandom), ty, len};
        in_error = err;
        model_frame(len, ty, err);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        logic [63:0] e [NC];
        for (int c = 0; c < NC; c++) e[c] = exp_rd(c, a);
        csr_read    = 1'b1;
        csr_address = a;
        cyc();
        csr_read    = 1'b0;
        for (int c = 0; c < NC; c++)
            chk($sformatf("rd_c%0d_a%0d", c, a), 64'(rdd[c]), e[c]);
        if (a == 4'd2)
            for (int c = 0; c < NC; c++) m_snap[c] = m_oct[c] >> cw[c];
    endtask

    task automatic rd_all();
        for (int a = 0; a < 16; a++) rd(4'(a));
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        csr_write     = 1'b1;
        csr_address   = a;
        csr_writedata = d;
        cyc();
        csr_write     = 1'b0;
        if (a == 4'd15 && d[0]) model_clear();
    endtask

    initial begin
        logic [15:0] len;
        logic [6:0]  err;
        int          n;

        model_clear();
        #2;
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("rst_ready_c%0d", c), 64'(rdy[c]), 64'd0);
            chk($sformatf("rst_rdata_c%0d", c), 64'(rdd[c]), 64'd0);
        end
        #11 reset_n = 1'b1;
        cyc();
        for (int c = 0; c < NC; c++)
            chk($sformatf("ready_c%0d", c), 64'(rdy[c]), 64'd1);
        rd_all();

        // Good frames, back to back
        send(16'd64, 4'b0001, 7'h00);
        send(16'd1518, 4'b0001, 7'h00);
        send(16'd100, 4'b0001, 7'h00);
        drain();
        rd(4'd0); chk("good_ok", 64'(rdd[0]), 64'd3);
        rd(4'd4); chk("good_uni", 64'(rdd[0]), 64'd3);
        rd(4'd2); chk("good_oct_lo", 64'(rdd[0]), 64'd1682);
        rd(4'd3); chk("good_oct_hi", 64'(rdd[0]), 64'd0);
        rd(4'd1); chk("good_err", 64'(rdd[0]), 64'd0);

        // Errored frames: crc, then only "other" bits
        send(16'd64, 4'b0001, 7'h02);
        drain();
        rd(4'd1); chk("err_frames1", 64'(rdd[0]), 64'd1);
        rd(4'd9); chk("err_crc", 64'(rdd[0]), 64'd1);
        rd(4'd2); chk("err_oct_same", 64'(rdd[0]), 64'd1682);
        send(16'd64, 4'b0000, 7'h50);
        drain();
        rd_all();
        chk("err_frames2", 64'(m_ev[0][1]), 64'd2);

        // Saturation versus wrap on the 4-bit configurations
        wr(4'd15, 32'd1);
        for (int i = 0; i < 20; i++) send(16'd64, 4'b0010, 7'h00);
        drain();
        rd(4'd0);
        chk("sat_ok_w4", 64'(rdd[2]), 64'd15);
        chk("wrap_ok_w4", 64'(rdd[3]), 64'd4);
        chk("sat_ok_w32", 64'(rdd[0]), 64'd20);
        rd_all();

        // Octet carry and snapshot coherence
        wr(4'd15, 32'd1);
        send(16'd200, 4'b0000, 7'h00);
        send(16'd100, 4'b0000, 7'h00);
        drain();
        rd(4'd2); chk("oct_lo_w8", 64'(rdd[1]), 64'h2C);
        send(16'd300, 4'b0000, 7'h00);
        drain();
        rd(4'd3); chk("oct_snap_w8", 64'(rdd[1]), 64'h01);
        rd(4'd2);
        rd(4'd3); chk("oct_snap2_w8", 64'(rdd[1]), 64'h02);

        // Clear in the same cycle a frame occupies S2
        send(16'd500, 4'b1111, 7'h00);
        send(16'd70, 4'b0000, 7'h0F);
        drain();
        csr_write     = 1'b1;
        csr_address   = 4'd15;
        csr_writedata = 32'd1;
        in_valid      = 1'b1;
        in_data       = {20'd0, 4'b0001, 16'd64};
        in_error      = 7'h00;
        model_clear();
        model_frame(16'd64, 4'b0001, 7'h00);
        cyc();
        csr_write = 1'b0;
        in_valid  = 1'b0;
        drain();
        rd(4'd0); chk("clr_ok", 64'(rdd[0]), 64'd1);
        rd(4'd15); chk("clr_ctrl", 64'(rdd[0]), 64'd0);
        rd_all();

        // Read of control in the same cycle as the clear write sees the old value
        send(16'd128, 4'b0100, 7'h00);
        drain();
        csr_read      = 1'b1;
        csr_write     = 1'b1;
        csr_address   = 4'd15;
        csr_writedata = 32'd1;
        cyc();
        csr_read  = 1'b0;
        csr_write = 1'b0;
        model_clear();
        for (int c = 0; c < NC; c++)
            chk($sformatf("rw15_c%0d", c), 64'(rdd[c]), 64'd0);
        drain();
        rd_all();

        // Ignored writes
        send(16'd1000, 4'b1000, 7'h00);
        wr(4'd0, 32'hFFFF_FFFF);
        wr(4'd15, 32'hFFFF_FFFE);
        wr(4'd7, 32'd1);
        drain();
        rd_all();

        // Randomized traffic with occasional gaps and clears
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(5, 30));
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       len = 16'd0;
                    1:       len = 16'hFFFF;
                    default: len = 16'($urandom);
                endcase
                err = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom_range(1, 127));
                send(len, 4'($urandom), err);
                if ($urandom_range(0, 4) == 0) cyc();
                if ($urandom_range(0, 40) == 0) wr(4'd15, 32'd1);
            end
            drain();
            rd_all();
        end

        // Asynchronous reset mid-stream
        rd(4'd0);
        send(16'd64, 4'b0001, 7'h00);
        send(16'd65, 4'b0001, 7'h00);
        send(16'd66, 4'b0001, 7'h00);
        #2 reset_n = 1'b0;
        #1;
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("mrst_ready_c%0d", c), 64'(rdy[c]), 64'd0);
            chk($sformatf("mrst_rdata_c%0d", c), 64'(rdd[c]), 64'd0);
        end
        reset_n = 1'b1;
        model_clear();
        cyc();
        for (int c = 0; c < NC; c++)
            chk($sformatf("mrst_ready_up_c%0d", c), 64'(rdy[c]), 64'd1);
        drain();
        rd_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
